// File: rtl/uart_dbg_tx_fifo.sv
// Debug byte FIFO that paces queued bytes into the UART transmitter's debug port.
// Define UART_DBG_TX_HEX_EN to send each byte as two uppercase ASCII hex characters.
module uart_dbg_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   i_wr_en,
    input  logic [7:0]             i_wr_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_overflow,
    input  logic                   i_clr_overflow,
    input  logic                   i_tx_ready,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    logic [7:0]    r_tx_data;
    logic [7:0]    w_tx_data_nxt;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_guard;
    logic [GW-1:0] w_guard_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_tx_start;

`ifdef UART_DBG_TX_HEX_EN
    logic       r_lo;
    logic       w_lo_nxt;
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;

    function automatic logic [7:0] f_hex(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction
`endif

    assign w_push      = i_wr_en & ~r_full;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LW'(DEPTH));
            r_empty    <= (w_level_nxt == '0);
            // A dropped push outranks a clear in the same cycle.
            r_overflow <= (i_wr_en & r_full) | (r_overflow & ~i_clr_overflow);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state   <= S_IDLE;
            r_guard   <= '0;
            r_tx_data <= 8'h00;
`ifdef UART_DBG_TX_HEX_EN
            r_lo      <= 1'b0;
            r_hold    <= 8'h00;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_guard   <= w_guard_nxt;
            r_tx_data <= w_tx_data_nxt;
`ifdef UART_DBG_TX_HEX_EN
            r_lo      <= w_lo_nxt;
            r_hold    <= w_hold_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_guard_nxt   = r_guard;
        w_tx_data_nxt = r_tx_data;
        w_pop         = 1'b0;
        w_tx_start    = 1'b0;
`ifdef UART_DBG_TX_HEX_EN
        w_lo_nxt      = r_lo;
        w_hold_nxt    = r_hold;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_empty && i_tx_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
`ifdef UART_DBG_TX_HEX_EN
                    w_hold_nxt    = r_mem[r_rd_ptr];
                    w_tx_data_nxt = f_hex(r_mem[r_rd_ptr][7:4]);
                    w_lo_nxt      = 1'b0;
`else
                    w_tx_data_nxt = r_mem[r_rd_ptr];
`endif
                end
            end
            S_START: begin
                w_tx_start  = 1'b1;
                w_guard_nxt = GW'(GUARD_CYCLES - 1);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // tx_ready is ignored until the guard expires; TX busy lags our launch.
                if (r_guard != '0) begin
                    w_guard_nxt = r_guard - GW'(1);
                end else if (i_tx_ready) begin
`ifdef UART_DBG_TX_HEX_EN
                    if (!r_lo) begin
                        w_lo_nxt      = 1'b1;
                        w_tx_data_nxt = f_hex(r_hold[3:0]);
                        w_state_nxt   = S_START;
                    end else begin
                        w_lo_nxt    = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;
    assign o_tx_start = w_tx_start;
    assign o_tx_data  = r_tx_data;

endmodule

// File: doc/uart_dbg_tx_fifo.md
Name: uart_dbg_tx_fifo

Overview:
Buffers debug bytes from the button-triggered debug sequencer and paces them into the UART transmitter's debug port.
- Sits between the debug sequence generator (upstream, single-cycle `wr_en` strobes) and `uart_if` `debug_send`/`debug_data` (downstream).
- Decouples the fixed-interval producer from the baud-limited transmitter, so no byte is lost while TX is busy.
- Overflow is reported through a sticky flag for register-bank readback.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2
- GUARD_CYCLES, 2, cycles after `tx_start` during which `tx_ready` is ignored (covers TX busy-flag latency); minimum 1

Ports:
- clk  in  1  system clock
- resetb  in  1  reset
- wr_en  in  1  push strobe from debug sequencer
- wr_data  in  8  byte to push
- full  out  1  FIFO full (registered)
- empty  out  1  FIFO empty (registered)
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a push was dropped
- clr_overflow  in  1  clears `overflow`
- tx_ready  in  1  transmitter idle, able to accept a byte
- tx_start  out  1  one-cycle launch pulse to TX (drives `debug_send`)
- tx_data  out  8  byte to send; stable from `tx_start` until the next `tx_start`

Behaviour:
- Reset: `resetb` is synchronous, active-low; clock is `clk`. While `resetb`=0, all of the following hold on every clock edge:
  - read and write pointers = 0, `level`=0, `empty`=1, `full`=0;
  - `overflow`=0, `tx_start`=0, `tx_data`=8'h00;
  - FSM = IDLE.
- Reset mid-transmission: the queued content is discarded. The byte already handed to TX is not recalled.
- Storage: circular buffer of DEPTH×8. Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is the authoritative count.
- Push:
  - When `wr_en`=1 and `full`=0 (value at the start of the cycle), `wr_data` is stored and the write pointer advances.
  - When `full`=1, the byte is dropped and `overflow` is set the next cycle. This holds even if a pop occurs in the same cycle.
- Pop: happens only on the FSM transition IDLE→START. The head byte is registered into `tx_data` and the read pointer advances.
- Simultaneous push and pop (not full): `level` is unchanged and both pointers advance.
- `overflow` priority: a set in the same cycle as `clr_overflow` wins, so the flag remains 1.
- FSM states:
  - IDLE: when `empty`=0 and `tx_ready`=1, pop and go to START. Otherwise stay.
  - START: `tx_start`=1 for exactly this one cycle. Load the guard counter with GUARD_CYCLES−1 and go to WAIT.
  - WAIT: decrement the guard counter to 0 while ignoring `tx_ready`. Once the counter is 0 and `tx_ready`=1, go to IDLE.
- Latency: a byte pushed at cycle N into an empty FIFO, with `tx_ready`=1 throughout, gives `tx_start`=1 at cycle N+2.
- Back-to-back bytes: minimum spacing between `tx_start` pulses is GUARD_CYCLES+2 cycles, and is otherwise set by `tx_ready`.
- `tx_start` is never asserted while `empty`=1 at pop time. `tx_start` is never asserted twice without an intervening WAIT.

Optional Feature:
- Macro: `UART_DBG_TX_HEX_EN`.
- When defined: each popped byte is sent as two uppercase ASCII hex characters, high nibble first ('0'–'9' = 8'h30–8'h39, 'A'–'F' = 8'h41–8'h46).
  - The FSM gains a HI/LO nibble flag. After the first WAIT completes, it returns to START with the low-nibble character, without popping again.
  - The next pop is taken only after the second WAIT completes.
  - 0x00–0x0F therefore become readable on a terminal.
- When undefined: the raw byte is sent unchanged and there is no nibble logic.

Test Plan:
1. Reset while holding 5 queued bytes and FSM in WAIT → next cycle `level`=0, `empty`=1, `tx_start`=0, `tx_data`=8'h00, `overflow`=0; no further `tx_start`.
2. Push 8'h44 at cycle N into empty FIFO, `tx_ready`=1 → `tx_start`=1 only at N+2, `tx_data`=8'h44; `level` returns to 0 at N+2.
3. Hold `tx_ready`=0, push 17 bytes 8'h00..8'h10 (DEPTH=16) → `full`=1 after 16 pushes, 17th dropped, `overflow`=1. Release `tx_ready` → TX sees 8'h00..8'h0F in order, `empty`=1 at end.
4. With `full`=1, assert `wr_en` and `clr_overflow` in the same cycle → `overflow`=1 afterwards. Lone `clr_overflow` next cycle → `overflow`=0.
5. Model TX busy for 20 cycles after each `tx_start`, push 3 bytes → exactly 3 `tx_start` pulses, spacing ≥ 22 cycles, `tx_data` stable between pulses.
6. With `UART_DBG_TX_HEX_EN`, push 8'h3A → two `tx_start` pulses with `tx_data`=8'h33 then 8'h41; FIFO pops once (`level` 1→0).
